regfile_ctrl: RTL and testbench

- Command-driven initiator that sits in front of the 8 x 16-bit register file (write port writenum/write/data_in, combinational read port readnum -> data_out).
- Accepts WRITE, MOV, READ and DUMP commands over a valid/ready channel and sequences the file's ports.
- Returns read data over a second valid/ready channel.
- Used by the datapath bring-up harness and the future instruction decoder as the single owner of the file's ports.

---
 rtl/regfile_ctrl.sv | 123 ++++++++++++
 tb/tb_regfile_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_ctrl.sv
// Command-driven port sequencer for an 8 x k-bit register file: WRITE, MOV, READ and DUMP
// commands in, read data out over a valid/ready response channel.
module regfile_ctrl #(
   parameter int k = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [1:0]   cmd_op,
   input  logic [2:0]   cmd_rd,
   input  logic [2:0]   cmd_rs,
   input  logic [k-1:0] cmd_imm,
   output logic [2:0]   rf_writenum,
   output logic         rf_write,
   output logic [k-1:0] rf_data_in,
   output logic [2:0]   rf_readnum,
   input  logic [k-1:0] rf_data_out,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [k-1:0] rsp_data,
   output logic [2:0]   rsp_reg,
   output logic         busy
);

   localparam logic [1:0] OP_WRITE = 2'd0;
   localparam logic [1:0] OP_MOV   = 2'd1;
   localparam logic [1:0] OP_READ  = 2'd2;
   localparam logic [1:0] OP_DUMP  = 2'd3;

   typedef enum logic [2:0] {IDLE, WR, MOV_RD, MOV_WR, RD, DUMP_RD, RESP} state_t;

   state_t       state;
   logic [1:0]   op;
   logic [2:0]   rd;
   logic [2:0]   rs;
   logic [2:0]   idx;
   logic [k-1:0] imm;
   logic [k-1:0] hold;

   // Write strobe comes purely from state so command inputs can never glitch it.
   assign rf_write    = (state == WR) || (state == MOV_WR);
   assign rf_writenum = rd;
   assign rf_data_in  = (state == MOV_WR) ? hold : imm;
   assign busy        = (state != IDLE);
   assign cmd_ready   = (state == IDLE) && !reset;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         op         <= OP_WRITE;
         rd         <= '0;
         rs         <= '0;
         imm        <= '0;
         idx        <= '0;
         hold       <= '0;
         rf_readnum <= '0;
         rsp_valid  <= 1'b0;
         rsp_data   <= '0;
         rsp_reg    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  op  <= cmd_op;
                  rd  <= cmd_rd;
                  rs  <= cmd_rs;
                  imm <= cmd_imm;
                  // Read address is set up at accept so the file output is valid in the read state.
                  case (cmd_op)
                     OP_WRITE: state <= WR;
                     OP_MOV: begin
                        state      <= MOV_RD;
                        rf_readnum <= cmd_rs;
                     end
                     OP_READ: begin
                        state      <= RD;
                        rf_readnum <= cmd_rs;
                     end
                     default: begin
                        state      <= DUMP_RD;
                        idx        <= '0;
                        rf_readnum <= '0;
                     end
                  endcase
               end
            end
            WR: state <= IDLE;
            MOV_RD: begin
               hold  <= rf_data_out;
               state <= MOV_WR;
            end
            MOV_WR: state <= IDLE;
            RD: begin
               rsp_data  <= rf_data_out;
               rsp_reg   <= rs;
               rsp_valid <= 1'b1;
               state     <= RESP;
            end
            DUMP_RD: begin
               rsp_data  <= rf_data_out;
               rsp_reg   <= idx;
               rsp_valid <= 1'b1;
               state     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  if (op == OP_DUMP && idx != 3'd7) begin
                     idx        <= idx + 3'd1;
                     rf_readnum <= idx + 3'd1;
                     state      <= DUMP_RD;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_ctrl.sv
// Bench for regfile_ctrl: behavioural register file on the ports, command-level reference
// model of register contents, expected response and write-effect queues.
module tb_regfile_ctrl;
   localparam int K = 16;
   localparam logic [1:0] OP_WRITE = 2'd0;
   localparam logic [1:0] OP_MOV   = 2'd1;
   localparam logic [1:0] OP_READ  = 2'd2;
   localparam logic [1:0] OP_DUMP  = 2'd3;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         cmd_valid = 1'b0;
   logic         cmd_ready;
   logic [1:0]   cmd_op = '0;
   logic [2:0]   cmd_rd = '0;
   logic [2:0]   cmd_rs = '0;
   logic [K-1:0] cmd_imm = '0;
   logic [2:0]   rf_writenum;
   logic         rf_write;
   logic [K-1:0] rf_data_in;
   logic [2:0]   rf_readnum;
   logic [K-1:0] rf_data_out;
   logic         rsp_valid;
   logic         rsp_ready = 1'b1;
   logic [K-1:0] rsp_data;
   logic [2:0]   rsp_reg;
   logic         busy;

   regfile_ctrl #(.k(K)) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_imm(cmd_imm),
      .rf_writenum(rf_writenum), .rf_write(rf_write), .rf_data_in(rf_data_in),
      .rf_readnum(rf_readnum), .rf_data_out(rf_data_out), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_reg(rsp_reg), .busy(busy)
   );

   always #5 clk = ~clk;

   // The register file itself, as the controller sees it.
   logic [K-1:0] rf [8];
   always @(posedge clk) if (rf_write) rf[rf_writenum] <= rf_data_in;
   assign rf_data_out = rf[rf_readnum];

   typedef struct packed {logic [2:0] r; logic [K-1:0] d;} ent_t;
   ent_t got_q[$], exp_q[$], wgot_q[$], wexp_q[$];
   logic [K-1:0] model [8];

   always @(posedge clk) begin
      if (!reset && rsp_valid && rsp_ready) got_q.push_back({rsp_reg, rsp_data});
      if (rf_write) wgot_q.push_back({rf_writenum, rf_data_in});
   end

   int tests = 0;
   int fails = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present a command from a falling edge and hold it until the controller takes it.
   task automatic issue(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs,
                        input logic [K-1:0] imm, input bit keep);
      int n = 0;
      cmd_op = op; cmd_rd = rd; cmd_rs = rs; cmd_imm = imm;
      while (n < 200) begin
         @(negedge clk);
         cmd_valid = 1'b1;
         if (cmd_ready) break;
         n++;
      end
      chk("accept_timeout", 32'(n < 200), 1);
      chk("accept_only_idle", 32'(busy), 0);
      @(posedge clk); #1;
      if (!keep) cmd_valid = 1'b0;
   endtask

   task automatic do_cmd(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs,
                         input logic [K-1:0] imm, input bit keep);
      issue(op, rd, rs, imm, keep);
      case (op)
         OP_WRITE: begin model[rd] = imm; wexp_q.push_back({rd, imm}); end
         OP_MOV: begin wexp_q.push_back({rd, model[rs]}); model[rd] = model[rs]; end
         OP_READ: exp_q.push_back({rs, model[rs]});
         default: for (int i = 0; i < 8; i++) exp_q.push_back({3'(i), model[i]});
      endcase
   endtask

   task automatic wait_done(input string tag, input bit rand_rdy);
      int n = 0;
      while (n < 600) begin
         @(negedge clk);
         if (rand_rdy) rsp_ready = 1'($urandom_range(0, 1));
         if (!busy && !rsp_valid) break;
         n++;
      end
      rsp_ready = 1'b1;
      chk({tag, "_done"}, 32'(n < 600), 1);
      chk({tag, "_nrsp"}, 32'(got_q.size()), 32'(exp_q.size()));
      while (exp_q.size() > 0 && got_q.size() > 0)
         chk({tag, "_rsp"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
      chk({tag, "_nwr"}, 32'(wgot_q.size()), 32'(wexp_q.size()));
      while (wexp_q.size() > 0 && wgot_q.size() > 0)
         chk({tag, "_wr"}, 32'(wgot_q.pop_front()), 32'(wexp_q.pop_front()));
      got_q.delete(); exp_q.delete(); wgot_q.delete(); wexp_q.delete();
   endtask

   initial begin
      int c;
      bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      ent_t prev;
      bit prev_stall;
      logic [2:0] ra, rb;
      logic [K-1:0] v;

      #1;
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_rsp_data", 32'(rsp_data), 0);
      chk("rst_rsp_reg", 32'(rsp_reg), 0);
      chk("rst_rf_write", 32'(rf_write), 0);
      chk("rst_writenum", 32'(rf_writenum), 0);
      chk("rst_data_in", 32'(rf_data_in), 0);
      chk("rst_readnum", 32'(rf_readnum), 0);
      chk("rst_busy", 32'(busy), 0);
      @(negedge clk); @(negedge clk);
      reset = 1'b0;
      #1 chk("rst_cmd_ready", 32'(cmd_ready), 1);

      // Fill every register, then dump with the consumer always ready.
      for (int n = 0; n < 8; n++) do_cmd(OP_WRITE, 3'(n), 3'd0, 16'(16'h1000 + n), 1'b0);
      wait_done("fill", 1'b0);
      do_cmd(OP_DUMP, 3'd0, 3'd0, 16'h0, 1'b0);
      c = 0;
      while (c < 100) begin
         @(negedge clk);
         if (!busy) break;
         c++;
      end
      chk("dump_cycles", 32'(c), 16);
      wait_done("dump", 1'b0);
      chk("dump_cmd_ready", 32'(cmd_ready), 1);

      // Single WRITE pulse, then READ back.
      do_cmd(OP_WRITE, 3'd3, 3'd0, 16'hBEEF, 1'b0);
      @(negedge clk);
      chk("wr_pulse", 32'(rf_write), 1);
      chk("wr_num", 32'(rf_writenum), 3);
      chk("wr_data", 32'(rf_data_in), 32'h0000BEEF);
      @(negedge clk);
      chk("wr_pulse_end", 32'(rf_write), 0);
      do_cmd(OP_READ, 3'd0, 3'd3, 16'h0, 1'b0);
      wait_done("wr_rd", 1'b0);

      // MOV writes in the second cycle after accept.
      do_cmd(OP_WRITE, 3'd1, 3'd0, 16'h1234, 1'b0);
      wait_done("mov_setup", 1'b0);
      do_cmd(OP_MOV, 3'd6, 3'd1, 16'h0, 1'b0);
      @(negedge clk);
      chk("mov_no_early_wr", 32'(rf_write), 0);
      @(negedge clk);
      chk("mov_wr", 32'(rf_write), 1);
      chk("mov_num", 32'(rf_writenum), 6);
      do_cmd(OP_READ, 3'd0, 3'd6, 16'h0, 1'b0);
      wait_done("mov", 1'b0);

      // DUMP under a 1-0-0-1 ready pattern with a stray command held on the input.
      do_cmd(OP_DUMP, 3'd0, 3'd0, 16'h0, 1'b0);
      cmd_op = OP_WRITE; cmd_rd = 3'd0; cmd_imm = 16'hDEAD; cmd_valid = 1'b1;
      prev_stall = 1'b0; prev = '0; c = 0;
      while (c < 200) begin
         @(negedge clk);
         if (!busy) break;
         if (rsp_valid && prev_stall) chk("stall_stable", 32'({rsp_reg, rsp_data}), 32'(prev));
         rsp_ready = pat[c % 4];
         if (rsp_valid && rsp_reg == 3'd7 && rsp_ready) cmd_valid = 1'b0;
         prev_stall = rsp_valid && !rsp_ready;
         prev = {rsp_reg, rsp_data};
         c++;
      end
      cmd_valid = 1'b0;
      wait_done("dump_toggle", 1'b0);

      // Reset while the write strobe is up: the write is lost.
      do_cmd(OP_WRITE, 3'd2, 3'd0, 16'h5555, 1'b0);
      wait_done("rst_wr_setup", 1'b0);
      issue(OP_WRITE, 3'd2, 3'd0, 16'hAAAA, 1'b0);
      chk("pre_rst_wr", 32'(rf_write), 1);
      #2 reset = 1'b1;
      #1;
      chk("rst_drops_write", 32'(rf_write), 0);
      chk("rst_wr_busy", 32'(busy), 0);
      chk("rst_wr_data_in", 32'(rf_data_in), 0);
      @(negedge clk); @(negedge clk);
      reset = 1'b0;
      do_cmd(OP_READ, 3'd0, 3'd2, 16'h0, 1'b0);
      wait_done("rst_wr", 1'b0);

      // Reset mid-DUMP with R4 on offer: nothing after R3 may be delivered.
      issue(OP_DUMP, 3'd0, 3'd0, 16'h0, 1'b0);
      for (int i = 0; i < 4; i++) exp_q.push_back({3'(i), model[i]});
      c = 0;
      while (c < 100) begin
         @(negedge clk);
         if (rsp_valid && rsp_reg == 3'd4) begin rsp_ready = 1'b0; break; end
         c++;
      end
      chk("dump_reach_r4", 32'(c < 100), 1);
      #2 reset = 1'b1;
      #1;
      chk("rst_dump_valid", 32'(rsp_valid), 0);
      chk("rst_dump_readnum", 32'(rf_readnum), 0);
      @(negedge clk);
      reset = 1'b0;
      rsp_ready = 1'b1;
      c = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (rsp_valid || busy) c++;
      end
      chk("rst_dump_quiet", 32'(c), 0);
      wait_done("rst_dump", 1'b0);

      // Back-to-back with cmd_valid held high.
      for (int t = 0; t < 4; t++) begin
         ra = 3'($urandom_range(0, 7)); rb = 3'($urandom_range(0, 7)); v = 16'($urandom);
         do_cmd(OP_WRITE, ra, 3'd0, v, 1'b1);
         do_cmd(OP_READ, 3'd0, ra, 16'h0, 1'b1);
         do_cmd(OP_MOV, rb, ra, 16'h0, 1'b0);
         do_cmd(OP_READ, 3'd0, rb, 16'h0, 1'b0);
         wait_done("b2b", 1'b0);
      end

      // Random command mix with a random consumer.
      for (int t = 0; t < 40; t++) begin
         do_cmd(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                16'($urandom), 1'b0);
         wait_done("rand", 1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
